// File: rtl/ctrl_pkg.sv
// Shared decode-stage definitions: opcode values, EX command and branch-type
// encodings, the decoded control bundle and its bubble (no-op) value.
package ctrl_pkg;

    // Opcode values as they appear in the instruction opcode field
    localparam int OP_NOP  = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_MUL  = 2;
    localparam int OP_SUB  = 3;
    localparam int OP_AND  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_NOR  = 7;
    localparam int OP_XOR  = 8;
    localparam int OP_SLA  = 9;
    localparam int OP_SLL  = 10;
    localparam int OP_SRA  = 11;
    localparam int OP_SRL  = 12;
    localparam int OP_ADDI = 32;
    localparam int OP_SUBI = 33;
    localparam int OP_LD   = 36;
    localparam int OP_ST   = 37;
    localparam int OP_BEZ  = 40;
    localparam int OP_BNE  = 41;
    localparam int OP_JMP  = 42;

    // ALU command seen by EX
    typedef enum logic [3:0] {
        CMD_ADD = 4'd0,
        CMD_SUB = 4'd2,
        CMD_MUL = 4'd3,
        CMD_AND = 4'd4,
        CMD_OR  = 4'd5,
        CMD_NOR = 4'd6,
        CMD_XOR = 4'd7,
        CMD_SHL = 4'd8,
        CMD_SRA = 4'd9,
        CMD_SRL = 4'd10
    } exe_cmd_e;

    // Branch kind resolved in EX
    typedef enum logic [1:0] {
        BR_BEZ  = 2'd0,
        BR_BNE  = 2'd1,
        BR_JMP  = 2'd2,
        BR_NONE = 2'd3
    } br_type_e;

    // Multi-cycle occupancy of EX
    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MUL_BUSY = 1'b1
    } mul_state_e;

    // Control fields carried from ID into EX
    typedef struct packed {
        exe_cmd_e cmd;
        br_type_e br_type;
        logic     mem_read;
        logic     mem_write;
        logic     wb_en;
        logic     is_imm;
        logic     one_input;
    } ctrl_t;

    // A bubble does nothing: no memory access, no write-back, no branch
    localparam ctrl_t CTRL_BUBBLE = '{
        cmd:       CMD_ADD,
        br_type:   BR_NONE,
        mem_read:  1'b0,
        mem_write: 1'b0,
        wb_en:     1'b0,
        is_imm:    1'b0,
        one_input: 1'b0
    };

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode -> control table plus register-usage flags.
// Undefined opcodes decode to the bubble control value.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic                uses1,
    output logic                uses2
);

    // Opcode table lookup
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        ctrl = CTRL_BUBBLE;
        case (opcode)
            OPCODE_W'(OP_ADD): ctrl.wb_en = 1'b1;
            OPCODE_W'(OP_MUL): begin ctrl.cmd = CMD_MUL; ctrl.wb_en = 1'b1; end
            OPCODE_W'(OP_SUB): begin ctrl.cmd = CMD_SUB; ctrl.wb_en = 1'b1; end
            OPCODE_W'(OP_AND): begin ctrl.cmd = CMD_AND; ctrl.wb_en = 1'b1; end
            OPCODE_W'(OP_OR):  begin ctrl.cmd = CMD_OR;  ctrl.wb_en = 1'b1; end
            OPCODE_W'(OP_NOR): begin ctrl.cmd = CMD_NOR; ctrl.wb_en = 1'b1; end
            OPCODE_W'(OP_XOR): begin ctrl.cmd = CMD_XOR; ctrl.wb_en = 1'b1; end
            OPCODE_W'(OP_SLA),
            OPCODE_W'(OP_SLL): begin ctrl.cmd = CMD_SHL; ctrl.wb_en = 1'b1; end
            OPCODE_W'(OP_SRA): begin ctrl.cmd = CMD_SRA; ctrl.wb_en = 1'b1; end
            OPCODE_W'(OP_SRL): begin ctrl.cmd = CMD_SRL; ctrl.wb_en = 1'b1; end
            OPCODE_W'(OP_ADDI): begin
                ctrl.is_imm    = 1'b1;
                ctrl.one_input = 1'b1;
                ctrl.wb_en     = 1'b1;
            end
            OPCODE_W'(OP_SUBI): begin
                ctrl.cmd       = CMD_SUB;
                ctrl.is_imm    = 1'b1;
                ctrl.one_input = 1'b1;
                ctrl.wb_en     = 1'b1;
            end
            OPCODE_W'(OP_LD): begin
                ctrl.is_imm    = 1'b1;
                ctrl.one_input = 1'b1;
                ctrl.wb_en     = 1'b1;
                ctrl.mem_read  = 1'b1;
            end
            OPCODE_W'(OP_ST): begin
                // Store reads src2 as its data register, so it is two-input
                ctrl.is_imm    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OPCODE_W'(OP_BEZ): begin
                ctrl.br_type   = BR_BEZ;
                ctrl.is_imm    = 1'b1;
                ctrl.one_input = 1'b1;
            end
            OPCODE_W'(OP_BNE): begin
                ctrl.br_type   = BR_BNE;
                ctrl.is_imm    = 1'b1;
            end
            OPCODE_W'(OP_JMP): begin
                ctrl.br_type   = BR_JMP;
                ctrl.is_imm    = 1'b1;
                ctrl.one_input = 1'b1;
            end
            default: ;
        endcase
    end

    // Which source fields the instruction actually reads
    always_comb begin
        uses1 = (opcode != OPCODE_W'(OP_NOP)) && (opcode != OPCODE_W'(OP_JMP));
        uses2 = !ctrl.one_input && (opcode != OPCODE_W'(OP_NOP));
    end

endmodule

// File: rtl/id_ctrl_pipe.sv
// Decode-stage control: RAW/load-use hazard detection, branch flush, MUL
// occupancy FSM and the ID/EX control pipeline register.
module id_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 6,
    parameter int REG_ADDR_W = 5,
    parameter bit FORWARD_EN = 1'b1,
    parameter int MUL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  branch_taken,
    output logic                  stall,
    output logic                  flush,
    output logic                  ex_valid,
    output logic [3:0]            ex_cmd,
    output logic [1:0]            ex_br_type,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_wb_en,
    output logic                  ex_is_imm,
    output logic                  ex_one_input,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  ex_busy
);

    localparam int CNT_W = $clog2(MUL_CYCLES);

    ctrl_t           dec;
    logic            uses1;
    logic            uses2;
    ctrl_t           ex_ctrl;
    logic            raw_ex;
    logic            raw_mem;
    logic            hazard;
    logic            load_mul;
    mul_state_e      state;
    logic [CNT_W-1:0] cnt;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode (opcode),
        .ctrl   (dec),
        .uses1  (uses1),
        .uses2  (uses2)
    );

    // RAW detection against the instructions in EX and MEM
    always_comb begin
        raw_ex  = ex_valid && ex_ctrl.wb_en && (ex_dest != '0) &&
                  ((uses1 && (ex_dest == src1)) || (uses2 && (ex_dest == src2)));
        raw_mem = mem_wb_en && (mem_dest != '0) &&
                  ((uses1 && (mem_dest == src1)) || (uses2 && (mem_dest == src2)));
        // With forwarding only a load result arrives too late for EX
        hazard  = FORWARD_EN ? (raw_ex && ex_ctrl.mem_read) : (raw_ex || raw_mem);
    end

    assign stall    = (hazard || ex_busy) && !branch_taken;
    assign flush    = branch_taken;
    assign load_mul = !branch_taken && !ex_busy && !hazard &&
                      (opcode == OPCODE_W'(OP_MUL));

    // ID/EX register: flush beats MUL hold, hold beats hazard bubble
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_BUBBLE;
            ex_dest  <= '0;
        end else if (branch_taken) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_BUBBLE;
            ex_dest  <= '0;
        end else if (ex_busy) begin
            ex_valid <= ex_valid;
            ex_ctrl  <= ex_ctrl;
            ex_dest  <= ex_dest;
        end else if (hazard) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_BUBBLE;
            ex_dest  <= '0;
        end else begin
            ex_valid <= 1'b1;
            ex_ctrl  <= dec;
            ex_dest  <= dest;
        end
    end

    // MUL occupancy: count down MUL_CYCLES-1 extra cycles after the MUL loads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ex_busy <= 1'b0;
        end else if (branch_taken) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ex_busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_mul) begin
                        state   <= S_MUL_BUSY;
                        cnt     <= CNT_W'(MUL_CYCLES - 1);
                        ex_busy <= 1'b1;
                    end
                end
                S_MUL_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        ex_busy <= 1'b0;
                    end else begin
                        cnt     <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    ex_busy <= 1'b0;
                end
            endcase
        end
    end

    assign ex_cmd       = ex_ctrl.cmd;
    assign ex_br_type   = ex_ctrl.br_type;
    assign ex_mem_read  = ex_ctrl.mem_read;
    assign ex_mem_write = ex_ctrl.mem_write;
    assign ex_wb_en     = ex_ctrl.wb_en;
    assign ex_is_imm    = ex_ctrl.is_imm;
    assign ex_one_input = ex_ctrl.one_input;

endmodule

// File: doc/id_ctrl_pipe.md
Name: id_ctrl_pipe

Overview:
- Second-generation decode-stage control: full opcode decode plus the ID/EX control pipeline register.
- Adds load-use/RAW hazard detection, branch flush, and a multi-cycle MUL hold.
- Sits between the IF/ID register and EX; drives PC/IF-ID freeze and the ID/EX control fields consumed by EX, MEM and WB.

Parameters:
- OPCODE_W, 6, opcode field width.
- REG_ADDR_W, 5, register address width (register 0 is hard-wired zero).
- FORWARD_EN, 1, 1 = forwarding present, so stall only on load-use; 0 = stall on any RAW against EX or MEM.
- MUL_CYCLES, 4, EX occupancy of MUL in cycles (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- opcode  in  OPCODE_W  ID instruction opcode
- src1  in  REG_ADDR_W  ID source 1
- src2  in  REG_ADDR_W  ID source 2 / store data register
- dest  in  REG_ADDR_W  ID destination
- mem_wb_en  in  1  MEM-stage instruction writes back
- mem_dest  in  REG_ADDR_W  MEM-stage destination
- branch_taken  in  1  EX resolved a taken branch/jump
- stall  out  1  freeze PC and IF/ID (combinational)
- flush  out  1  squash IF/ID (combinational, equals branch_taken)
- ex_valid  out  1  ID/EX holds a real instruction
- ex_cmd  out  4  ALU command
- ex_br_type  out  2  0 BEZ, 1 BNE, 2 JMP, 3 none
- ex_mem_read  out  1  ID/EX control bit
- ex_mem_write  out  1  ID/EX control bit
- ex_wb_en  out  1  ID/EX control bit
- ex_is_imm  out  1  ID/EX control bit
- ex_one_input  out  1  ID/EX control bit
- ex_dest  out  REG_ADDR_W  registered destination
- ex_busy  out  1  multi-cycle MUL occupying EX

Behaviour:
- Decode (combinational):
  - Opcodes: NOP 0, ADD 1, MUL 2, SUB 3, AND 5, OR 6, NOR 7, XOR 8, SLA 9, SLL 10, SRA 11, SRL 12, ADDI 32, SUBI 33, LD 36, ST 37, BEZ 40, BNE 41, JMP 42.
  - cmd: ADD/ADDI/LD/ST/JMP 0; SUB/SUBI 2; MUL 3; AND 4; OR 5; NOR 6; XOR 7; SLA/SLL 8; SRA 9; SRL 10; all others 0. No X outputs.
  - is_imm = ADDI, SUBI, LD, ST, BEZ, BNE, JMP.
  - one_input = ADDI, SUBI, LD, BEZ, JMP.
  - mem_read = LD; mem_write = ST.
  - wb_en = 1 except NOP, ST, BEZ, BNE, JMP, and undefined opcodes, which are 0.
- Source usage:
  - uses1 = opcode not NOP/JMP.
  - uses2 = not one_input and opcode not NOP.
- RAW detection:
  - raw_ex = ex_valid & ex_wb_en & ex_dest!=0 & ((uses1 & ex_dest==src1) | (uses2 & ex_dest==src2)).
  - raw_mem: same comparison using mem_wb_en and mem_dest.
  - hazard = FORWARD_EN ? (raw_ex & ex_mem_read) : (raw_ex | raw_mem).
- Outputs:
  - stall = (hazard | ex_busy) & ~branch_taken.
  - flush = branch_taken.
- FSM, states IDLE and MUL_BUSY, down-counter cnt of width clog2(MUL_CYCLES):
  - IDLE → MUL_BUSY when the ID/EX register loads a valid MUL; cnt <= MUL_CYCLES-1.
  - MUL_BUSY: cnt decrements each cycle; ex_busy = (state==MUL_BUSY).
  - MUL_BUSY → IDLE when cnt==1 on the clock edge. MUL therefore occupies EX for exactly MUL_CYCLES cycles.
- ID/EX update priority, per clock edge:
  1. flush → bubble (ex_valid=0, all enables 0, ex_cmd 0, ex_br_type 3, ex_dest 0); FSM → IDLE, aborting any MUL.
  2. ex_busy → hold all ID/EX contents.
  3. hazard → bubble.
  4. otherwise load decoded ID fields, ex_valid=1.
- Reset (rst=0, async):
  - ID/EX outputs take bubble values: ex_valid 0, ex_br_type 3, all other outputs 0.
  - FSM IDLE, cnt 0.
  - Reset mid-MUL abandons it.
- Latency: decode-to-ID/EX 1 cycle. stall and flush respond in the same cycle as their cause.
- Boundaries:
  - dest/src 0 never cause a hazard.
  - Back-to-back MULs: the second waits in ID under stall, loads on the cycle busy clears, and restarts the count.
  - Hazard and busy together: busy hold dominates.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams
  - EXE_CMD encodings, including MUL=3
  - br_type encodings (BEZ 0, BNE 1, JMP 2, NONE 3)
  - bubble default values
- Sub-module ctrl_decode holds the pure combinational opcode→control table, reusable by other stages.
- id_ctrl_pipe holds hazard logic, FSM and the ID/EX register.

Test Plan:
- Reset: hold rst=0 with random inputs → ex_valid 0, ex_br_type 3, stall 0, ex_busy 0. Release → ADD (opcode 1) loads next edge with ex_cmd 0, ex_wb_en 1.
- Load-use, FORWARD_EN=1: LD dest=5, then SUB src1=5 → stall=1 for 1 cycle, one bubble in ID/EX, SUB enters the following cycle. Same sequence with ADD instead of LD → no stall.
- FORWARD_EN=0: ADD dest=3, then AND src2=3 → stall 2 cycles (EX then MEM match). dest=0 producer → no stall.
- MUL, MUL_CYCLES=4: MUL then ADD → ex_busy high 3 cycles, ID/EX held, stall high 3 cycles, ADD loads on the 4th edge. Back-to-back MULs → 3+3 busy cycles.
- Flush: branch_taken=1 while ID holds a hazarding instruction → stall 0, flush 1, next ID/EX bubble. branch_taken asserted during MUL_BUSY → FSM IDLE, ex_busy 0 next cycle.
- Undefined opcode 63 → ex_valid 1, ex_wb_en 0, ex_mem_read 0, ex_mem_write 0, ex_cmd 0, ex_br_type 3; no X on any output.
